fsm_fetch_dispatch: RTL and testbench



---
 rtl/fsm_fetch_dispatch.sv | 155 +++++++++++++++
 tb/tb_fsm_fetch_dispatch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_fetch_dispatch.sv
// Control-unit sequencer: fetch, decode settle, one-hot dispatch to an
// execution FSM, wait for its done, retire; traps on bad decode or hangs.
module fsm_fetch_dispatch #(
    parameter logic [31:0] MASK_ALU = 32'h00FF_FFFF,
    parameter logic [31:0] MASK_MEM = 32'h3800_0000,
    parameter logic [31:0] MASK_BJ  = 32'h0700_0000,
    parameter logic [31:0] MASK_FP  = 32'hC000_0000,
    parameter logic [9:0]  TIMEOUT  = 10'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] fetch_data,
    input  logic        fetch_done,
    output logic        fetch_start,
    output logic [31:0] insn,
    input  logic [31:0] code,
    output logic        start_alu,
    output logic        start_mem,
    output logic        start_bj,
    output logic        start_fp,
    input  logic        done_alu,
    input  logic        done_mem,
    input  logic        done_bj,
    input  logic        done_fp,
    output logic        busy,
    output logic [63:0] retired,
    output logic        trap,
    output logic [1:0]  trap_cause,
    input  logic        clear_trap
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_DISPATCH,
        S_WAIT_DONE,
        S_RETIRE,
        S_TRAP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] insn_q, insn_d;
    logic [63:0] retired_q, retired_d;
    logic [9:0]  timer_q, timer_d;
    logic [1:0]  cause_q, cause_d;
    logic [3:0]  hit_q, hit_d;

    logic [3:0]  hit_w;
    logic [3:0]  done_w;
    logic        hit_onehot;

    assign hit_w = {|(code & MASK_FP), |(code & MASK_BJ),
                    |(code & MASK_MEM), |(code & MASK_ALU)};
    assign done_w = {done_fp, done_bj, done_mem, done_alu};
    assign hit_onehot = (hit_q != 4'd0) && ((hit_q & (hit_q - 4'd1)) == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            insn_q    <= '0;
            retired_q <= '0;
            timer_q   <= '0;
            cause_q   <= '0;
            hit_q     <= '0;
        end else begin
            state_q   <= state_d;
            insn_q    <= insn_d;
            retired_q <= retired_d;
            timer_q   <= timer_d;
            cause_q   <= cause_d;
            hit_q     <= hit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        insn_d    = insn_q;
        retired_d = retired_q;
        timer_d   = timer_q;
        cause_d   = cause_q;
        hit_d     = hit_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                timer_d = '0;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                timer_d = timer_q + 10'd1;
                if (fetch_done) begin
                    insn_d  = fetch_data;
                    state_d = S_DECODE;
                end else if (timer_q == TIMEOUT) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end
            end
            // code has settled by now; registering it keeps start_* free of
            // any combinational path from the opdecoder.
            S_DECODE: begin
                hit_d   = hit_w;
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (hit_onehot) begin
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    cause_d = 2'b01;
                    state_d = S_TRAP;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_q + 10'd1;
                if ((done_w & hit_q) != 4'd0) begin
                    state_d = S_RETIRE;
                end else if (timer_q == TIMEOUT) begin
                    cause_d = 2'b11;
                    state_d = S_TRAP;
                end
            end
            S_RETIRE: begin
                retired_d = retired_q + 64'd1;
                state_d   = run ? S_FETCH_REQ : S_IDLE;
            end
            S_TRAP: begin
                if (clear_trap) begin
                    cause_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [3:0] start_w;
    assign start_w = (state_q == S_DISPATCH && hit_onehot) ? hit_q : 4'd0;

    assign fetch_start = (state_q == S_FETCH_REQ);
    assign start_alu   = start_w[0];
    assign start_mem   = start_w[1];
    assign start_bj    = start_w[2];
    assign start_fp    = start_w[3];
    assign busy        = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign trap        = (state_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign insn        = insn_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fsm_fetch_dispatch.sv
// Scoreboard bench for fsm_fetch_dispatch: directed programs push expected
// events; a negedge monitor pops and compares each observed event.
module tb_fsm_fetch_dispatch;

    localparam int EV_FETCH = 0;
    localparam int EV_START = 1;
    localparam int EV_TRAP  = 2;
    localparam int EV_RET   = 3;

    typedef struct {
        int          kind;
        int          delta;
        logic [63:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] fetch_data = 32'h0020_8463;
    logic        fetch_done = 1'b0;
    logic        fetch_start;
    logic [31:0] insn;
    logic [31:0] code = 32'h0;
    logic        start_alu, start_mem, start_bj, start_fp;
    logic        done_alu = 1'b0, done_mem = 1'b0;
    logic        done_bj = 1'b0, done_fp = 1'b0;
    logic        busy;
    logic [63:0] retired;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        clear_trap = 1'b0;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_fs = 0;
    int  fdelay = 0;
    logic [63:0] ret_prev = 64'd0;
    logic        trap_prev = 1'b0;

    always #5 clk = ~clk;

    fsm_fetch_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .fetch_data (fetch_data),
        .fetch_done (fetch_done),
        .fetch_start(fetch_start),
        .insn       (insn),
        .code       (code),
        .start_alu  (start_alu),
        .start_mem  (start_mem),
        .start_bj   (start_bj),
        .start_fp   (start_fp),
        .done_alu   (done_alu),
        .done_mem   (done_mem),
        .done_bj    (done_bj),
        .done_fp    (done_fp),
        .busy       (busy),
        .retired    (retired),
        .trap       (trap),
        .trap_cause (trap_cause),
        .clear_trap (clear_trap)
    );

    task automatic expect_ev(input int k, input int d, input logic [63:0] v);
        ev_t e;
        e.kind  = k;
        e.delta = d;
        e.val   = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int d, input logic [63:0] v);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event kind=%0d delta=%0d val=%0h (none required)",
                     k, d, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.delta == d && e.val == v) n_pass++;
            else $display("FAIL event got kind=%0d delta=%0d val=%0h required kind=%0d delta=%0d val=%0h",
                          k, d, v, e.kind, e.delta, e.val);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s got=%0h required=%0h", name, act, req);
    endtask

    // which: 0 = any start pulse, 1 = trap
    task automatic wait_sig(input int which, input int bound);
        int n;
        logic seen;
        n = 0;
        seen = (which == 0) ? (start_alu | start_mem | start_bj | start_fp) : trap;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            seen = (which == 0) ? (start_alu | start_mem | start_bj | start_fp) : trap;
        end
        n_chk++;
        if (seen) n_pass++;
        else $display("FAIL wait_timeout which=%0d got=none required=event", which);
    endtask

    task automatic do_clear();
        run = 1'b0;
        @(negedge clk);
        clear_trap = 1'b1;
        @(negedge clk);
        clear_trap = 1'b0;
        check("clear_trap_trap", {63'd0, trap}, 64'd0);
        check("clear_trap_cause", {62'd0, trap_cause}, 64'd0);
        check("clear_trap_busy", {63'd0, busy}, 64'd0);
    endtask

    // Monitor: retire, fetch, start, trap in that order within a cycle.
    initial begin
        logic [3:0] sv;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                ret_prev  = retired;
                trap_prev = trap;
            end else begin
                if (retired != ret_prev) got(EV_RET, cyc - last_fs, retired);
                ret_prev = retired;
                if (fetch_start) begin
                    got(EV_FETCH, 0, 64'd0);
                    last_fs = cyc;
                end
                sv = {start_fp, start_bj, start_mem, start_alu};
                if (sv != 4'd0) got(EV_START, cyc - last_fs, {60'd0, sv});
                if (trap && !trap_prev) got(EV_TRAP, cyc - last_fs, {62'd0, trap_cause});
                trap_prev = trap;
            end
        end
    end

    // Memory controller: answers a fetch after fdelay extra cycles, or never.
    initial begin
        forever begin
            @(negedge clk);
            if (fetch_start && fdelay >= 0) begin
                repeat (1 + fdelay) @(negedge clk);
                fetch_done = 1'b1;
                @(negedge clk);
                fetch_done = 1'b0;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_trap", {63'd0, trap}, 64'd0);
        check("rst_fetch_start", {63'd0, fetch_start}, 64'd0);
        check("rst_insn", {32'd0, insn}, 64'd0);
        check("rst_retired", retired, 64'd0);
        check("rst_cause", {62'd0, trap_cause}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Branch dispatch, then an ALU op that sees a wrong-FSM done and run drop
        fdelay = 0;
        code = 32'h0100_0000;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_START, 3, 64'h4);
        expect_ev(EV_RET, 6, 64'd1);
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_START, 3, 64'h1);
        expect_ev(EV_RET, 11, 64'd2);
        run = 1'b1;
        wait_sig(0, 20);
        check("insn_beq", {32'd0, insn}, 64'h0020_8463);
        @(negedge clk);
        done_bj = 1'b1;
        @(negedge clk);
        done_bj = 1'b0;
        code = 32'h0000_0001;
        wait_sig(0, 20);
        done_bj = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done_bj = 1'b0;
        run = 1'b0;
        repeat (4) @(negedge clk);
        done_alu = 1'b1;
        @(negedge clk);
        done_alu = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_run_drop", {63'd0, busy}, 64'd0);

        // Illegal (zero) and ambiguous (ALU+BJ) decodes
        code = 32'h0;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_TRAP, 4, 64'd1);
        run = 1'b1;
        wait_sig(1, 20);
        do_clear();
        code = 32'h0100_0001;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_TRAP, 4, 64'd1);
        run = 1'b1;
        wait_sig(1, 20);
        do_clear();

        // Fetch timeout: trap TIMEOUT+1 cycles after entering FETCH_WAIT
        fdelay = -1;
        code = 32'h0000_0001;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_TRAP, 1025, 64'd2);
        run = 1'b1;
        wait_sig(1, 1100);
        do_clear();

        // Execute timeout on a load/store op
        fdelay = 0;
        code = 32'h0800_0000;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_START, 3, 64'h2);
        expect_ev(EV_TRAP, 1028, 64'd3);
        run = 1'b1;
        wait_sig(1, 1100);
        do_clear();

        // Async reset in WAIT_DONE; the late done must be discarded
        code = 32'h0000_0001;
        expect_ev(EV_FETCH, 0, 64'd0);
        expect_ev(EV_START, 3, 64'h1);
        expect_ev(EV_RET, 5, 64'd0);
        run = 1'b1;
        wait_sig(0, 20);
        run = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_insn", {32'd0, insn}, 64'd0);
        check("arst_retired", retired, 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        done_alu = 1'b1;
        @(negedge clk);
        done_alu = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_retired", retired, 64'd0);
        check("post_rst_busy", {63'd0, busy}, 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
